// File: rtl/tdc_pkg.sv
// Shared constants and helpers for the TDC hit-encoder slice.
// Optional bubble filter selected by the TDC_BUBBLE_FILTER_EN macro.
package tdc_pkg;

    localparam int TAPS_DEF     = 32;
    localparam int COARSE_W_DEF = 16;
    localparam int DROP_W       = 8;

    // Width needed to hold a tap count from 0 up to and including taps.
    function automatic int fine_w(input int taps);
        return $clog2(taps + 1);
    endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// Combinational thermometer-to-count encoder for the delay-line taps.
// Macro TDC_BUBBLE_FILTER_EN: defined  -> population count (bubbles lower the count),
//                             undefined -> highest set tap index + 1 (bubbles ignored).
module tdc_therm_encoder
    import tdc_pkg::*;
#(
    parameter int TAPS = TAPS_DEF,
    localparam int FINE_W = fine_w(TAPS)
) (
    input  logic [TAPS-1:0]   therm,
    output logic [FINE_W-1:0] fine
);

`ifdef TDC_BUBBLE_FILTER_EN
    // Count every set tap so a bubble in the code reduces the result.
    always_comb begin
        fine = '0;
        for (int i = 0; i < TAPS; i++) begin
            fine = fine + FINE_W'(therm[i]);
        end
    end
`else
    // Position of the furthest set tap; zeros below it are ignored.
    always_comb begin
        fine = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (therm[i]) begin
                fine = FINE_W'(i + 1);
            end
        end
    end
`endif

endmodule

// File: rtl/tdc_hit_encoder.sv
// TDC capture stage: samples the delay-line taps, detects a rising edge on
// tap 0, encodes the fine count and pairs it with a free-running coarse count
// on a valid/ready output register. Encoding mode set by TDC_BUBBLE_FILTER_EN
// (see tdc_therm_encoder); latency is 2 cycles in both modes.
module tdc_hit_encoder
    import tdc_pkg::*;
#(
    parameter int TAPS     = TAPS_DEF,
    parameter int COARSE_W = COARSE_W_DEF,
    localparam int FINE_W  = fine_w(TAPS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [TAPS-1:0]     taps,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [COARSE_W-1:0] out_coarse,
    output logic [FINE_W-1:0]   out_fine,
    output logic [DROP_W-1:0]   drop_count
);

    logic [COARSE_W-1:0] coarse_cnt;

    logic [TAPS-1:0]     samp_p0;
    logic [COARSE_W-1:0] coarse_p0;
    logic [TAPS-1:0]     samp_p1;
    logic [COARSE_W-1:0] coarse_p1;
    logic                prev_p2;

    logic [FINE_W-1:0]   fine;
    logic                hit;
    logic                reg_free;

    // Free-running coarse counter, wraps naturally at its width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coarse_cnt <= '0;
        end else begin
            coarse_cnt <= coarse_cnt + COARSE_W'(1);
        end
    end

    // ---- S0: sample. samp_p0 takes taps directly and is the only flop allowed to go metastable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_p0   <= '0;
            coarse_p0 <= '0;
        end else begin
            samp_p0   <= taps;
            coarse_p0 <= coarse_cnt;
        end
    end

    // ---- S1: settle. prev_p2 remembers tap 0 from the previous settled sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_p1   <= '0;
            coarse_p1 <= '0;
            prev_p2   <= 1'b0;
        end else begin
            samp_p1   <= samp_p0;
            coarse_p1 <= coarse_p0;
            prev_p2   <= samp_p1[0];
        end
    end

    tdc_therm_encoder #(
        .TAPS (TAPS)
    ) u_enc (
        .therm (samp_p1),
        .fine  (fine)
    );

    // Only a rising edge on tap 0 is a hit; the pulse trailing edge is ignored.
    assign hit      = samp_p1[0] & ~prev_p2;
    assign reg_free = ~out_valid | out_ready;

    // ---- S2: output register. A transfer and a new load may share one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_coarse <= '0;
            out_fine   <= '0;
        end else if (hit && reg_free) begin
            out_valid  <= 1'b1;
            out_coarse <= coarse_p1;
            out_fine   <= fine;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    // Count hits discarded because the held word was not yet accepted; saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
        end else if (hit && !reg_free && (drop_count != {DROP_W{1'b1}})) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_tdc_hit_encoder.sv
// Scoreboard bench for tdc_hit_encoder (TAPS=32, COARSE_W=4 so wrap is frequent).
module tb_tdc_hit_encoder;

    localparam int TAPS     = 32;
    localparam int COARSE_W = 4;
    localparam int FINE_W   = $clog2(TAPS + 1);

    logic                clk;
    logic                rst_n;
    logic [TAPS-1:0]     taps;
    logic                out_valid;
    logic                out_ready;
    logic [COARSE_W-1:0] out_coarse;
    logic [FINE_W-1:0]   out_fine;
    logic [7:0]          drop_count;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    tdc_hit_encoder #(
        .TAPS     (TAPS),
        .COARSE_W (COARSE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .taps       (taps),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_coarse (out_coarse),
        .out_fine   (out_fine),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference fine count straight from the encoding rules.
    function automatic int ref_fine(input logic [31:0] t);
`ifdef TDC_BUBBLE_FILTER_EN
        return $countones(t);
`else
        for (int i = 31; i >= 0; i--) begin
            if (t[i]) return i + 1;
        end
        return 0;
`endif
    endfunction

    typedef struct { bit hit; int coarse; int fine; } cand_t;
    typedef struct { int coarse; int fine; } word_t;

    cand_t cand_q[$];
    word_t exp_q[$];
    bit    m_valid;
    int    m_drop;
    int    m_cnt;
    bit    m_prev;

    // Reference model: each sampling edge yields a candidate; it reaches the
    // output register two edges later, where it is loaded or dropped.
    initial begin
        cand_t c;
        cand_t d;
        word_t w;
        m_valid = 0; m_drop = 0; m_cnt = 0; m_prev = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                cand_q.delete();
                exp_q.delete();
                m_valid = 0; m_drop = 0; m_cnt = 0; m_prev = 0;
            end else begin
                c.hit    = taps[0] && !m_prev;
                c.coarse = m_cnt % (1 << COARSE_W);
                c.fine   = ref_fine(taps);
                m_prev   = taps[0];
                m_cnt++;
                cand_q.push_back(c);
                if (cand_q.size() > 2) begin
                    d = cand_q.pop_front();
                    if (d.hit) begin
                        if (!m_valid || out_ready) begin
                            w.coarse = d.coarse;
                            w.fine   = d.fine;
                            exp_q.push_back(w);
                            m_valid = 1;
                        end else if (m_drop < 255) begin
                            m_drop++;
                        end
                    end else if (m_valid && out_ready) begin
                        m_valid = 0;
                    end
                end
            end
        end
    end

    // Monitor: compare whatever the DUT presents; pop on each transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid", 32'(out_valid), 32'(m_valid));
                check("drop_count", 32'(drop_count), 32'(m_drop));
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_word", 32'(out_valid), 32'd0);
                    end else begin
                        check("coarse", 32'(out_coarse), 32'(exp_q[0].coarse));
                        check("fine", 32'(out_fine), 32'(exp_q[0].fine));
                        if (out_ready) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    initial begin
        int n;
        logic [31:0] t;
        rst_n     = 1'b0;
        taps      = 32'h1;
        out_ready = 1'b1;

        // Reset state, tap 0 already high at release.
        repeat (2) @(posedge clk);
        #2;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        check("rst_coarse", 32'(out_coarse), 32'd0);
        check("rst_fine", 32'(out_fine), 32'd0);
        rst_n = 1'b1;
        cyc   = 0;
        step();
        taps = '0;
        step();
        step();
        check("first_valid", 32'(out_valid), 32'd1);
        check("first_coarse", 32'(out_coarse), 32'd0);
        check("first_fine", 32'(out_fine), 32'd1);

        // Clean hit sampled when coarse_cnt is 5.
        while (cyc != 5) step();
        taps = 32'h0000_00FF;
        step();
        taps = '0;
        step();
        step();
        check("clean_valid", 32'(out_valid), 32'd1);
        check("clean_fine", 32'(out_fine), 32'd8);
        check("clean_coarse", 32'(out_coarse), 32'd5);

        // Bubble in the thermometer code.
        taps = 32'h0000_00FB;
        step();
        taps = '0;
        step();
        step();
`ifdef TDC_BUBBLE_FILTER_EN
        check("bubble_fine", 32'(out_fine), 32'd7);
`else
        check("bubble_fine", 32'(out_fine), 32'd8);
`endif
        repeat (3) step();

        // Backpressure: two hits four cycles apart, second one dropped.
        out_ready = 1'b0;
        taps = 32'h3;
        step();
        taps = '0;
        repeat (3) step();
        taps = 32'h7;
        step();
        taps = '0;
        step();
        step();
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_fine_held", 32'(out_fine), 32'd2);
        check("bp_drop", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("bp_after_pulse", 32'(out_valid), 32'd0);

        // Transfer and new load on the same edge.
        taps = 32'h1F;
        step();
        taps = '0;
        step();
        taps = 32'h0000_FFFF;
        step();
        taps = '0;
        step();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("simul_valid", 32'(out_valid), 32'd1);
        check("simul_fine", 32'(out_fine), 32'd16);
        check("simul_drop", 32'(drop_count), 32'd1);
        out_ready = 1'b1;
        repeat (3) step();

        // Coarse wrap: hit at count 15, next hit three cycles later at count 2.
        while ((cyc % 16) != 15) step();
        taps = 32'h1;
        step();
        taps = '0;
        step();
        step();
        check("wrap_coarse15", 32'(out_coarse), 32'd15);
        taps = 32'h3;
        step();
        taps = '0;
        step();
        step();
        check("wrap_coarse2", 32'(out_coarse), 32'd2);
        check("wrap_fine2", 32'(out_fine), 32'd2);

        // Randomised traffic with random backpressure.
        for (int k = 0; k < 400; k++) begin
            n = $urandom_range(0, 32);
            t = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
            if (($urandom % 5) == 0) t[$urandom % 32] = 1'b0;
            if (($urandom % 3) == 0) t = '0;
            taps      = t;
            out_ready = (($urandom % 4) != 0);
            step();
        end

        // Mid-operation reset with a stalled word.
        out_ready = 1'b0;
        taps = 32'h1;
        step();
        taps = '0;
        step();
        step();
        step();
        check("stall_before_reset", 32'(out_valid), 32'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_drop", 32'(drop_count), 32'd0);
        repeat (2) step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
